qed_i_cache: RTL and testbench

Replay buffer directly downstream of the QED instruction-modification stage. While the core runs original instructions, it captures each register/immediate-remapped duplicate instruction (qed_instruction) into a circular buffer. When duplicate mode is requested, it replays the captured duplicates in program order to the QED instruction mux, one per unstalled cycle. It reports full/empty so the QED controller can decide when to switch modes and when the duplicate half is complete.

---
 rtl/qed_i_cache_if.sv | 26 ++
 rtl/qed_i_cache.sv | 77 +++++++
 tb/tb_qed_i_cache.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/qed_i_cache_if.sv
// Bus between the QED controller/modification stage and the replay buffer.
// The master drives mode, stall and capture data; the slave returns replay data and occupancy.
interface qed_i_cache_if #(
    parameter int AW = 4
);
    logic          ena;
    logic          exec_dup;
    logic          stall_IF;
    logic          if_valid;
    logic [31:0]   qed_instruction;
    logic [31:0]   qic_qimux_instruction;
    logic          qic_valid;
    logic          qic_full;
    logic          qic_empty;
    logic [AW:0]   qic_count;

    modport master (
        output ena, exec_dup, stall_IF, if_valid, qed_instruction,
        input  qic_qimux_instruction, qic_valid, qic_full, qic_empty, qic_count
    );

    modport slave (
        input  ena, exec_dup, stall_IF, if_valid, qed_instruction,
        output qic_qimux_instruction, qic_valid, qic_full, qic_empty, qic_count
    );
endinterface

// File: rtl/qed_i_cache.sv
// Circular replay buffer: captures duplicate instructions in original mode and
// replays them in program order, one per unstalled cycle, in duplicate mode.
module qed_i_cache #(
    parameter int          DEPTH = 16,
    parameter int          AW    = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst_n,
    qed_i_cache_if.slave  bus
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic [31:0]   out_q,    out_d;
    logic          valid_q,  valid_d;
    logic          full, empty, wr_en, rd_en;

    // Occupancy comes from the count alone, so pointer equality never matters.
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    assign wr_en = bus.ena && !bus.stall_IF && !bus.exec_dup && bus.if_valid && !full;
    assign rd_en = bus.ena && !bus.stall_IF &&  bus.exec_dup && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        valid_d  = valid_q;
        if (!bus.ena) begin
            out_d   = NOP;
            valid_d = 1'b0;
        end else if (!bus.stall_IF) begin
            out_d   = NOP;
            valid_d = 1'b0;
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + (AW+1)'(1);
            end else if (rd_en) begin
                out_d    = mem[rd_ptr_q];
                valid_d  = 1'b1;
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= NOP;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.qed_instruction;
    end

    assign bus.qic_qimux_instruction = out_q;
    assign bus.qic_valid             = valid_q;
    assign bus.qic_full              = full;
    assign bus.qic_empty             = empty;
    assign bus.qic_count             = count_q;
endmodule

// File: tb/tb_qed_i_cache.sv
// Bench for qed_i_cache: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_qed_i_cache;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    bit   chk_en;

    qed_i_cache_if #(.AW(AW)) bus ();

    qed_i_cache #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: a plain FIFO queue plus the expected output register
    logic [31:0] exp_q[$];
    logic [31:0] m_out;
    logic        m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_out   = NOP;
            m_valid = 1'b0;
        end else if (!bus.ena) begin
            m_out   = NOP;
            m_valid = 1'b0;
        end else if (!bus.stall_IF) begin
            m_out   = NOP;
            m_valid = 1'b0;
            if (!bus.exec_dup) begin
                if (bus.if_valid && exp_q.size() < DEPTH) exp_q.push_back(bus.qed_instruction);
            end else if (exp_q.size() > 0) begin
                m_out   = exp_q.pop_front();
                m_valid = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("instr", bus.qic_qimux_instruction, m_out);
            chk("valid", 32'(bus.qic_valid), 32'(m_valid));
            chk("count", 32'(bus.qic_count), 32'(exp_q.size()));
            chk("full",  32'(bus.qic_full),  32'(exp_q.size() == DEPTH));
            chk("empty", 32'(bus.qic_empty), 32'(exp_q.size() == 0));
        end
    end

    // driver: apply inputs just after a falling edge, advance to the next falling edge
    task automatic cyc(input bit e, input bit d, input bit s, input bit v, input logic [31:0] ins);
        bus.ena             = e;
        bus.exec_dup        = d;
        bus.stall_IF        = s;
        bus.if_valid        = v;
        bus.qed_instruction = ins;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cyc(1, 1, 0, 0, 32'h0);
    endtask

    task automatic check_out(input string name, input logic [31:0] ins, input bit v, input int cnt);
        chk({name, "_instr"}, bus.qic_qimux_instruction, ins);
        chk({name, "_valid"}, 32'(bus.qic_valid), 32'(v));
        chk({name, "_count"}, 32'(bus.qic_count), 32'(cnt));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.ena = 0; bus.exec_dup = 0; bus.stall_IF = 0; bus.if_valid = 0;
        bus.qed_instruction = '0;
        repeat (2) @(negedge clk);
        check_out("reset", NOP, 0, 0);
        chk("reset_empty", 32'(bus.qic_empty), 32'd1);
        chk("reset_full",  32'(bus.qic_full),  32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // three captures then replay
        cyc(1, 0, 0, 1, 32'h00A10093);
        cyc(1, 0, 0, 1, 32'h40B50533);
        cyc(1, 0, 0, 1, 32'h01052283);
        check_out("cap3", NOP, 0, 3);
        cyc(1, 1, 0, 0, 32'h0); check_out("rep1", 32'h00A10093, 1, 2);
        cyc(1, 1, 0, 0, 32'h0); check_out("rep2", 32'h40B50533, 1, 1);
        cyc(1, 1, 0, 0, 32'h0); check_out("rep3", 32'h01052283, 1, 0);
        chk("rep3_empty", 32'(bus.qic_empty), 32'd1);
        cyc(1, 1, 0, 0, 32'h0); check_out("rep_nop", NOP, 0, 0);

        // fill to full, 17th dropped
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, 0, 0, 1, 32'hC0DE0000 + 32'(i));
        chk("full_flag", 32'(bus.qic_full), 32'd1);
        chk("full_count", 32'(bus.qic_count), 32'd16);
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 32'h0);
        check_out("full_last", 32'hC0DE000F, 1, 0);
        cyc(1, 1, 0, 0, 32'h0); check_out("full_17th", NOP, 0, 0);

        // stall mid-replay
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 32'h5A000000 + 32'(i));
        cyc(1, 1, 0, 0, 32'h0);
        cyc(1, 1, 0, 0, 32'h0); check_out("pre_stall", 32'h5A000001, 1, 3);
        cyc(1, 1, 1, 0, 32'h0); check_out("stall1", 32'h5A000001, 1, 3);
        cyc(1, 1, 1, 1, 32'hFFFFFFFF); check_out("stall2", 32'h5A000001, 1, 3);
        cyc(1, 1, 0, 0, 32'h0); check_out("post_stall", 32'h5A000002, 1, 2);
        drain();

        // capture 10, replay 4, capture 8 more (wraps pointers)
        for (int i = 1; i <= 10; i++) cyc(1, 0, 0, 1, 32'hA0000000 + 32'(i));
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 32'h0);
        for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 1, 32'hB0000000 + 32'(i));
        chk("wrap_count", 32'(bus.qic_count), 32'd14);
        cyc(1, 1, 0, 0, 32'h0); check_out("wrap_first", 32'hA0000005, 1, 13);
        for (int i = 0; i < 13; i++) cyc(1, 1, 0, 0, 32'h0);
        check_out("wrap_last", 32'hB0000008, 1, 0);

        // asynchronous reset between edges mid-replay
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 32'h77000000 + 32'(i));
        cyc(1, 1, 0, 0, 32'h0);
        #3 rst_n = 1'b0;
        #1 check_out("areset", NOP, 0, 0);
        chk("areset_empty", 32'(bus.qic_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // replay mode ignores if_valid while empty
        cyc(1, 1, 0, 1, 32'hDEADBEEF);
        cyc(1, 1, 0, 1, 32'hDEADBEEF); check_out("dup_nowrite", NOP, 0, 0);

        // ena low freezes state and forces NOP
        cyc(1, 0, 0, 1, 32'h12345678);
        cyc(1, 1, 0, 0, 32'h0);
        cyc(0, 1, 0, 1, 32'h0); check_out("ena_off", NOP, 0, 0);

        // randomized traffic
        begin
            bit d;
            d = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) == 0) d = ~d;
                cyc(($urandom_range(0, 9) != 0), d, ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) < 7), $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
